// File: rtl/header_parse_if.sv
// RMII dibit stream bundle: dibits enter on axiiv/axiid and payload dibits leave on axiov/axiod.
interface header_parse_if;
    logic       axiiv;
    logic [1:0] axiid;
    logic       axiov;
    logic [1:0] axiod;

    modport master (output axiiv, output axiid, input axiov, input axiod);
    modport slave  (input axiiv, input axiid, output axiov, output axiod);
endinterface

// File: rtl/header_parse.sv
// Ethernet II header parser. Reassembles dst/src/ethertype from post-SFD dibits,
// filters on station/broadcast address and ethertype, and forwards accepted payload.
module header_parse #(
    parameter logic [47:0] MY_MAC    = 48'h692C_0830_75FD,
    parameter logic [15:0] ETHERTYPE = 16'h0800
) (
    input  logic                clk,
    input  logic                rst,
    header_parse_if.slave       bus,
    output logic                hdr_valid,
    output logic [47:0]         dest_mac,
    output logic [47:0]         src_mac,
    output logic [15:0]         ethertype,
    output logic                accept,
    output logic                frame_done,
    output logic                runt
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] HEADER  = 2'd1;
    localparam logic [1:0] PAYLOAD = 2'd2;
    localparam logic [1:0] DROP    = 2'd3;

    localparam logic [47:0] BCAST_MAC  = 48'hFFFF_FFFF_FFFF;
    localparam logic [5:0]  LAST_DIBIT = 6'd55;
    localparam logic [5:0]  HDR_DIBITS = 6'd56;

    logic [1:0]   state_r;
    logic [5:0]   count_r;
    logic [111:0] hdr_r;
    logic         rearm_r;

    logic [6:0]   idx_s;
    logic [111:0] hdr_next_s;
    logic         match_s;

    // Merge the incoming dibit into the header image; byte k lands at [111-8k -: 8], LSB dibit first.
    always_comb begin
        idx_s      = 7'd104 - {count_r[5:2], 3'b000} + {4'b0000, count_r[1:0], 1'b0};
        hdr_next_s = hdr_r;
        hdr_next_s[idx_s +: 2] = bus.axiid;
        match_s    = ((hdr_next_s[111:64] == MY_MAC) || (hdr_next_s[111:64] == BCAST_MAC)) &&
                     (hdr_next_s[15:0] == ETHERTYPE);
    end

    // Frame FSM, header capture and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            count_r    <= 6'd0;
            hdr_r      <= 112'd0;
            rearm_r    <= 1'b1;
            bus.axiov  <= 1'b0;
            bus.axiod  <= 2'd0;
            hdr_valid  <= 1'b0;
            dest_mac   <= 48'd0;
            src_mac    <= 48'd0;
            ethertype  <= 16'd0;
            accept     <= 1'b0;
            frame_done <= 1'b0;
            runt       <= 1'b0;
        end else begin
            bus.axiov  <= 1'b0;
            bus.axiod  <= 2'd0;
            hdr_valid  <= 1'b0;
            frame_done <= 1'b0;
            runt       <= 1'b0;

            // A frame cut by reset must be seen to end before IDLE trusts axiiv again.
            if (!bus.axiiv) begin
                rearm_r <= 1'b0;
            end else begin
                rearm_r <= rearm_r;
            end

            case (state_r)
                IDLE: begin
                    if (bus.axiiv && !rearm_r) begin
                        hdr_r   <= hdr_next_s;
                        count_r <= 6'd1;
                        accept  <= 1'b0;
                        state_r <= HEADER;
                    end else begin
                        count_r <= 6'd0;
                    end
                end
                HEADER: begin
                    if (bus.axiiv) begin
                        hdr_r <= hdr_next_s;
                        if (count_r == LAST_DIBIT) begin
                            count_r   <= HDR_DIBITS;
                            hdr_valid <= 1'b1;
                            dest_mac  <= hdr_next_s[111:64];
                            src_mac   <= hdr_next_s[63:16];
                            ethertype <= hdr_next_s[15:0];
                            accept    <= match_s;
                            state_r   <= match_s ? PAYLOAD : DROP;
                        end else begin
                            count_r <= count_r + 6'd1;
                        end
                    end else begin
                        runt    <= 1'b1;
                        count_r <= 6'd0;
                        state_r <= IDLE;
                    end
                end
                PAYLOAD: begin
                    if (bus.axiiv) begin
                        bus.axiov <= 1'b1;
                        bus.axiod <= bus.axiid;
                    end else begin
                        frame_done <= 1'b1;
                        count_r    <= 6'd0;
                        state_r    <= IDLE;
                    end
                end
                DROP: begin
                    if (!bus.axiiv) begin
                        count_r <= 6'd0;
                        state_r <= IDLE;
                    end else begin
                        state_r <= DROP;
                    end
                end
                default: begin
                    count_r <= 6'd0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/header_parse.md
# header_parse

Receive-side counterpart of the Ethernet header generator. Consumes the post-SFD RMII dibit stream, reassembles the 14-byte Ethernet II header (destination MAC, source MAC, ethertype), and decides whether to accept the frame. On accept, it forwards the payload dibits unchanged to the downstream depacketizer; otherwise it drops the rest of the frame. It sits between the preamble/SFD stripper and the payload/FCS stage of the decoder-side Ethernet receive path.

## Interface
Parameters:
- MY_MAC, 48'h692C_0830_75FD: local station address. A frame is accepted if its destination equals MY_MAC or the broadcast address 48'hFFFF_FFFF_FFFF.
- ETHERTYPE, 16'h0800: the only ethertype accepted.

Ports:
- clk  input  1  system clock; one dibit per cycle at most.
- rst  input  1  synchronous, active-high reset.
- axiiv  input  1  input dibit valid. High for the whole frame body after SFD; the first low cycle marks end of frame.
- axiid  input  2  input dibit, RMII order.
- axiov  output  1  payload dibit valid.
- axiod  output  2  payload dibit, same order as received.
- hdr_valid  output  1  one-cycle pulse when the full header has been captured.
- dest_mac  output  48  captured destination MAC; first byte on wire is [47:40].
- src_mac  output  48  captured source MAC; first byte is [47:40].
- ethertype  output  16  captured ethertype; first byte is [15:8].
- accept  output  1  header matched; held until the next frame starts.
- frame_done  output  1  one-cycle pulse at the end of an accepted frame.
- runt  output  1  one-cycle pulse when a frame ends before 56 dibits.

## Operation
- Dibit order within a byte is LSB-first. Byte b arrives as b[1:0], b[3:2], b[5:4], b[7:6]. Bytes are assembled as {d3,d2,d1,d0}.
- Header length is 56 dibits (14 bytes). A 6-bit dibit counter covers 0..55.
- Field layout:
  - bytes 0–5 go to dest_mac, MSB byte first.
  - bytes 6–11 go to src_mac.
  - bytes 12–13 go to ethertype.
- States:
  - IDLE: waiting. On axiiv=1, capture dibit 0 (count=1) and go to HEADER.
  - HEADER: capture each valid dibit.
    - axiiv=0 before count reaches 56: pulse runt, go to IDLE, accept stays 0.
    - On the 56th dibit: evaluate accept = (dest==MY_MAC or broadcast) and ethertype==ETHERTYPE, using the final byte as it is merged. Go to PAYLOAD if accept, else DROP.
  - PAYLOAD: each axiiv=1 dibit is forwarded. axiiv=0 pulses frame_done and goes to IDLE.
  - DROP: ignore input. axiiv=0 goes to IDLE with no pulse.
- Output reset values: axiov=0, axiod=0, hdr_valid=0, dest_mac=0, src_mac=0, ethertype=0, accept=0, frame_done=0, runt=0. State resets to IDLE and the counter to 0.
- Field outputs update only when hdr_valid pulses and hold until the next header completes. Partial captures are kept in an internal shift register, not on the outputs.
- accept clears to 0 on the first dibit of a new frame.
- Reset mid-frame: return to IDLE immediately with no pulses. The remainder of that frame is treated as a new frame only after axiiv has been seen low. A rearm flag is set by rst and cleared by axiiv=0; while it is set, IDLE ignores axiiv=1.
- The counter saturates at 56; payload length is unbounded.

## Timing
- The 56th header dibit is sampled at edge T. hdr_valid=1 and fields/accept are valid during cycle T+1.
- Payload latency is 1 cycle: a dibit sampled at edge T+k (k≥1) appears on axiod with axiov=1 in cycle T+k+1.
- axiod is registered; it is 0 whenever axiov=0.
- End of frame: the first axiiv=0 sampled at edge E gives frame_done (or runt) =1 during cycle E+1. axiov=0 in that same cycle.
- A new frame may start on the cycle immediately after the axiiv=0 cycle. There is no dead time.
- No backpressure exists; the downstream stage must take every dibit.

## Test plan
- Unicast: dest=69:2C:08:30:75:FD, src=FF:FF:FF:FF:FF:FF, type 08:00, then 8 payload dibits 0,1,2,3,3,2,1,0, then axiiv=0.
  - hdr_valid 1 cycle after dibit 56, with dest_mac=48'h692C083075FD, ethertype=16'h0800, accept=1.
  - The 8 dibits appear in order 1 cycle late, followed by a frame_done pulse.
- Broadcast dest FF:..:FF with type 0800 -> accept=1 and payload forwarded.
- Dest 02:00:00:00:00:01 -> hdr_valid pulses with accept=0; axiov stays 0 for the whole frame; no frame_done.
- Type 86:DD with matching dest -> accept=0 and the frame is dropped.
- Runt: axiiv low after 30 dibits -> one runt pulse, no hdr_valid, axiov never high.
- rst asserted at payload dibit 3, and a two-frame sequence separated by a 1-cycle axiiv gap:
  - rst -> all outputs 0 the next cycle; the trailing dibits are ignored until axiiv goes low.
  - Gapped frames -> both are parsed, each with its own hdr_valid and frame_done.
